apb_fifo_completer: RTL and testbench

//  APB completer that bridges the APB bus to a local streaming interface through two FIFOs.
//  - TX FIFO: APB writes to DATA push into it; the local side pops it via out_valid/out_ready.
//  - RX FIFO: the local side pushes into it via in_valid/in_ready; APB reads of DATA pop it.

---
 rtl/apb_fifo_completer.sv | 231 +++++++++++++++++++++++
 tb/tb_apb_fifo_completer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_fifo_completer.sv
// APB completer bridging the bus to a local stream through a TX and an RX FIFO.
// Optional macro APB_FIFO_IRQ_EN adds a registered irq output and CTRL interrupt enables.
module apb_fifo_completer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready
`ifdef APB_FIFO_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int PW  = $clog2(DEPTH);
  localparam int C   = PW + 1;
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TX  = 0;
  localparam int RX  = 1;

  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_CTRL     = 2'd2;
  localparam logic [1:0] REG_UNMAPPED = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;

  typedef struct packed {
    logic       wr;
    logic [1:0] reg_sel;
    logic       is_data;
    logic       bad;
  } req_t;

  state_t                       state_q, state_d;
  logic [WCW-1:0]               wcnt_q, wcnt_d;
  req_t                         req;
  logic                         res_ok, complete, ctrl_wr, err_clr;
  logic                         block_en, err_sticky;
  logic [DATA_WIDTH-1:0]        status, ctrl_rd, rd_val;

  logic [1:0][DATA_WIDTH-1:0]   wr_data, rd_data;
  logic [1:0][C-1:0]            count;
  logic [1:0]                   push, pop, flush, full, empty;

  logic unused_addr;
  assign unused_addr = ^PADDR[ADDR_WIDTH-1:2];

  // Index 0 is the TX FIFO, index 1 the RX FIFO; flush acts like a local reset.
  for (genvar f = 0; f < 2; f++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [C-1:0]          cnt_q;

    always_ff @(posedge PCLK) begin
      if (!PRESETN || flush[f]) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt_q  <= '0;
      end else begin
        if (push[f]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[f])  rd_ptr <= rd_ptr + 1'b1;
        cnt_q <= cnt_q + C'(push[f]) - C'(pop[f]);
      end
    end

    always_ff @(posedge PCLK) begin
      if (push[f]) mem[wr_ptr] <= wr_data[f];
    end

    assign rd_data[f] = mem[rd_ptr];
    assign count[f]   = cnt_q;
    assign full[f]    = (cnt_q == C'(DEPTH));
    assign empty[f]   = (cnt_q == '0);
  end

  assign req = '{wr:      PWRITE,
                 reg_sel: PADDR[1:0],
                 is_data: (PADDR[1:0] == REG_DATA),
                 bad:     (PADDR[1:0] == REG_UNMAPPED) ||
                          ((PADDR[1:0] == REG_STATUS) && PWRITE)};

  // Readiness uses registered counts only, so a same-cycle local pop/push never passes through.
  assign res_ok = !(req.is_data &&  req.wr && full[TX]) &&
                  !(req.is_data && !req.wr && empty[RX]);

  assign ctrl_wr   = complete && req.wr && (req.reg_sel == REG_CTRL);
  assign flush[TX] = ctrl_wr && PWDATA[0];
  assign flush[RX] = ctrl_wr && PWDATA[1];
  assign err_clr   = ctrl_wr && PWDATA[3];

  assign wr_data[TX] = PWDATA;
  assign wr_data[RX] = in_data;
  assign push[TX]    = complete && req.is_data && req.wr;
  assign pop[TX]     = out_ready && !empty[TX] && !flush[TX];
  assign in_ready    = PRESETN && !full[RX] && !flush[RX];
  assign push[RX]    = in_valid && in_ready;
  assign pop[RX]     = complete && req.is_data && !req.wr;

  assign out_data  = rd_data[TX];
  assign out_valid = !empty[TX];

  always_comb begin
    status              = '0;
    status[C-1:0]       = count[TX];
    status[2*C-1:C]     = count[RX];
    status[2*C]         = full[TX];
    status[2*C+1]       = empty[RX];
    status[2*C+2]       = err_sticky;
  end

`ifdef APB_FIFO_IRQ_EN
  logic ie_rx, ie_tx;
`endif

  always_comb begin
    ctrl_rd    = '0;
    ctrl_rd[2] = block_en;
`ifdef APB_FIFO_IRQ_EN
    ctrl_rd[4] = ie_rx;
    ctrl_rd[5] = ie_tx;
`endif
  end

  always_comb begin
    rd_val = '0;
    unique case (req.reg_sel)
      REG_DATA:   rd_val = rd_data[RX];
      REG_STATUS: rd_val = status;
      REG_CTRL:   rd_val = ctrl_rd;
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    PREADY   = 1'b0;
    PSLVERR  = 1'b0;
    PRDATA   = '0;
    complete = 1'b0;
    unique case (state_q)
      S_IDLE: if (PSEL && !PENABLE) state_d = S_ACCESS;
      S_ACCESS, S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
        end else if (req.bad) begin
          PREADY  = 1'b1;
          PSLVERR = 1'b1;
          state_d = S_IDLE;
        end else if (res_ok) begin
          PREADY   = 1'b1;
          complete = 1'b1;
          PRDATA   = req.wr ? '0 : rd_val;
          state_d  = S_IDLE;
        end else if (state_q == S_ACCESS) begin
          if (block_en) begin
            // The access cycle itself is the first wait-state cycle.
            state_d = S_WAIT;
            wcnt_d  = WCW'(1);
          end else begin
            PREADY  = 1'b1;
            PSLVERR = 1'b1;
            state_d = S_IDLE;
          end
        end else if ((TIMEOUT != 0) && (wcnt_q == WCW'(TIMEOUT))) begin
          PREADY  = 1'b1;
          PSLVERR = 1'b1;
          state_d = S_IDLE;
        end else if (TIMEOUT != 0) begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!PRESETN) begin
      PREADY   = 1'b0;
      PSLVERR  = 1'b0;
      PRDATA   = '0;
      complete = 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      block_en   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (ctrl_wr) block_en <= PWDATA[2];
      if (PREADY && PSLVERR) err_sticky <= 1'b1;
      else if (err_clr)      err_sticky <= 1'b0;
    end
  end

`ifdef APB_FIFO_IRQ_EN
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      ie_rx <= 1'b0;
      ie_tx <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ie_rx <= PWDATA[4];
        ie_tx <= PWDATA[5];
      end
      irq <= (ie_rx && !empty[RX]) || (ie_tx && empty[TX]);
    end
  end
`endif

endmodule

// File: tb/tb_apb_fifo_completer.sv
// Bench for apb_fifo_completer: directed table, multi-cycle corner sequences, random traffic vs queue model.
module tb_apb_fifo_completer;
  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          PCLK = 1'b0, PRESETN = 1'b0;
  logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [DW-1:0] PWDATA = '0;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;

  int n_checks = 0;
  int n_fail   = 0;

  apb_fifo_completer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(15)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready));

  always #5 PCLK = ~PCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Full APB transfer; waits = number of access-phase cycles with PREADY low.
  task automatic apb(input logic wr, input logic [1:0] a, input logic [DW-1:0] wd,
                     output logic [DW-1:0] rd, output logic err, output int waits);
    logic [AW-1:0] ad;
    ad = AW'($urandom);
    ad[1:0] = a;
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = ad; PWDATA = wd;
    @(negedge PCLK);
    PENABLE = 1'b1;
    waits = 0;
    #1;
    while (!PREADY && waits < 100) begin
      waits++;
      @(negedge PCLK);
      #1;
    end
    chk("apb_pready", PREADY, 1);
    rd  = PRDATA;
    err = PSLVERR;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_status(input int tc, input int rc, input logic st);
    logic [DW-1:0] s;
    s = '0;
    s[4:0]  = tc[4:0];
    s[9:5]  = rc[4:0];
    s[10]   = (tc == DEPTH);
    s[11]   = (rc == 0);
    s[12]   = st;
    return s;
  endfunction

  typedef struct {
    logic          wr;
    logic [1:0]    addr;
    logic [DW-1:0] wd;
    logic          err;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t tbl[16];

  logic [DW-1:0] txq[$];
  logic [DW-1:0] rxq[$];
  logic          sticky;

  initial begin
    logic [DW-1:0] rd, d, exp_rd;
    logic          err, e, iv, orr, done;
    int            w, k, r;

    tbl[0]  = '{1'b1, 2'd0, 16'h1111, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 2'd0, 16'h2222, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 2'd1, 16'h0000, 1'b0, 16'h0802};
    tbl[3]  = '{1'b1, 2'd1, 16'hFFFF, 1'b1, 16'h0000};
    tbl[4]  = '{1'b1, 2'd3, 16'h00FF, 1'b1, 16'h0000};
    tbl[5]  = '{1'b0, 2'd3, 16'h0000, 1'b1, 16'h0000};
    tbl[6]  = '{1'b0, 2'd1, 16'h0000, 1'b0, 16'h1802};
    tbl[7]  = '{1'b1, 2'd2, 16'h0008, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 2'd1, 16'h0000, 1'b0, 16'h0802};
    tbl[9]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 16'h0000};
    tbl[10] = '{1'b1, 2'd2, 16'h0009, 1'b0, 16'h0000};
    tbl[11] = '{1'b0, 2'd1, 16'h0000, 1'b0, 16'h0800};
    tbl[12] = '{1'b1, 2'd2, 16'h0004, 1'b0, 16'h0000};
    tbl[13] = '{1'b0, 2'd2, 16'h0000, 1'b0, 16'h0004};
    tbl[14] = '{1'b1, 2'd2, 16'h0033, 1'b0, 16'h0000};
    tbl[15] = '{1'b0, 2'd2, 16'h0000, 1'b0, 16'h0000};

    // Reset state
    repeat (3) @(negedge PCLK);
    #1;
    chk("rst_pready", PREADY, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge PCLK);
    PRESETN = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Write with zero wait states, visible on the stream one cycle later
    out_ready = 1'b1;
    apb(1'b1, 2'd0, 16'hA5A5, rd, err, w);
    chk("a5_waits", w, 0);
    chk("a5_err", err, 0);
    #1;
    chk("a5_out_valid", out_valid, 1);
    chk("a5_out_data", out_data, 16'hA5A5);
    @(negedge PCLK);
    out_ready = 1'b0;
    #1;
    chk("a5_popped", out_valid, 0);

    // Local push then APB read
    @(negedge PCLK);
    in_valid = 1'b1; in_data = 16'h1234;
    #1;
    chk("push_in_ready", in_ready, 1);
    @(negedge PCLK);
    in_valid = 1'b0;
    apb(1'b0, 2'd0, 16'h0, rd, err, w);
    chk("rx_rd_data", rd, 16'h1234);
    chk("rx_rd_err", err, 0);
    apb(1'b0, 2'd1, 16'h0, rd, err, w);
    chk("rx_status", rd, 16'h0800);

    // Directed register table
    foreach (tbl[i]) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wd, rd, err, w);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
      chk($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_waits", i), w, 0);
    end

    // Blocking write into a full TX FIFO, released by a pop in wait cycle 5
    apb(1'b1, 2'd2, 16'h0004, rd, err, w);
    for (int i = 0; i < DEPTH; i++) begin
      apb(1'b1, 2'd0, DW'(16'h0100 + i), rd, err, w);
      chk("fill_err", err, 0);
    end
    apb(1'b0, 2'd1, 16'h0, rd, err, w);
    chk("full_status", rd, 16'h0C10);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = '0; PWDATA = 16'hBEEF;
    @(negedge PCLK);
    PENABLE = 1'b1;
    k = 0; done = 1'b0; err = 1'b0;
    while (!done && k < 40) begin
      out_ready = (k == 5);
      #1;
      if (PREADY) begin
        done = 1'b1;
        err  = PSLVERR;
      end else begin
        k++;
        @(negedge PCLK);
      end
    end
    chk("blk_wr_low_cycles", k, 6);
    chk("blk_wr_err", err, 0);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; out_ready = 1'b0;
    apb(1'b0, 2'd1, 16'h0, rd, err, w);
    chk("blk_wr_status", rd, 16'h0C10);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge PCLK);
      out_ready = 1'b1;
      #1;
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, (i < DEPTH - 1) ? DW'(16'h0101 + i) : 16'hBEEF);
    end
    @(negedge PCLK);
    out_ready = 1'b0;
    #1;
    chk("drain_empty", out_valid, 0);

    // Blocking read timeout with RX empty
    apb(1'b0, 2'd0, 16'h0, rd, err, w);
    chk("tmo_low_cycles", w, 15);
    chk("tmo_err", err, 1);
    chk("tmo_rd", rd, 0);
    apb(1'b0, 2'd1, 16'h0, rd, err, w);
    chk("tmo_sticky", rd, 16'h1800);
    apb(1'b1, 2'd2, 16'h0008, rd, err, w);
    apb(1'b0, 2'd1, 16'h0, rd, err, w);
    chk("clr_status", rd, 16'h0800);

    // RX flush while the local side keeps pushing
    @(negedge PCLK);
    in_valid = 1'b1; in_data = 16'h5A5A;
    repeat (3) @(negedge PCLK);
    in_valid = 1'b0;
    apb(1'b0, 2'd1, 16'h0, rd, err, w);
    chk("rx3_status", rd, 16'h0060);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'd2; PWDATA = 16'h0002; in_valid = 1'b1;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    chk("flush_pready", PREADY, 1);
    chk("flush_in_ready", in_ready, 0);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; in_valid = 1'b0;
    apb(1'b0, 2'd1, 16'h0, rd, err, w);
    chk("flush_status", rd, 16'h0800);

    // Reset in the middle of a write access
    apb(1'b1, 2'd2, 16'h0004, rd, err, w);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = '0; PWDATA = 16'h7777;
    @(negedge PCLK);
    PENABLE = 1'b1; PRESETN = 1'b0;
    #1;
    chk("midrst_pready", PREADY, 0);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PRESETN = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    apb(1'b0, 2'd2, 16'h0, rd, err, w);
    chk("midrst_ctrl", rd, 16'h0000);

    // Random traffic against a queue model (non-blocking mode)
    txq.delete(); rxq.delete(); sticky = 1'b0;
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 15);
      if (r <= 3) begin
        d = DW'($urandom);
        e = (txq.size() == DEPTH);
        apb(1'b1, 2'd0, d, rd, err, w);
        chk("rnd_wr_err", err, e);
        chk("rnd_wr_waits", w, 0);
        if (e) sticky = 1'b1; else txq.push_back(d);
      end else if (r <= 6) begin
        e = (rxq.size() == 0);
        exp_rd = e ? '0 : rxq[0];
        apb(1'b0, 2'd0, DW'($urandom), rd, err, w);
        chk("rnd_rd_err", err, e);
        chk("rnd_rd_data", rd, exp_rd);
        if (e) sticky = 1'b1; else void'(rxq.pop_front());
      end else if (r == 7) begin
        apb(1'b0, 2'd1, DW'($urandom), rd, err, w);
        chk("rnd_status", rd, exp_status(txq.size(), rxq.size(), sticky));
      end else if (r == 8) begin
        if ($urandom_range(0, 1) == 1) apb(1'b1, 2'd1, DW'($urandom), rd, err, w);
        else apb(1'($urandom_range(0, 1)), 2'd3, DW'($urandom), rd, err, w);
        chk("rnd_bad_err", err, 1);
        chk("rnd_bad_rd", rd, 0);
        sticky = 1'b1;
      end else if (r == 9) begin
        d = DW'($urandom) & 16'hFFF0;
        d[0] = ($urandom_range(0, 7) == 0);
        d[1] = ($urandom_range(0, 7) == 0);
        d[3] = ($urandom_range(0, 3) == 0);
        apb(1'b1, 2'd2, d, rd, err, w);
        chk("rnd_ctrl_err", err, 0);
        if (d[0]) txq.delete();
        if (d[1]) rxq.delete();
        if (d[3]) sticky = 1'b0;
      end else begin
        iv  = ($urandom_range(0, 3) != 0);
        orr = ($urandom_range(0, 3) == 0);
        d   = DW'($urandom);
        @(negedge PCLK);
        in_valid = iv; in_data = d; out_ready = orr;
        #1;
        chk("rnd_out_valid", out_valid, txq.size() != 0);
        if (txq.size() != 0) chk("rnd_out_data", out_data, txq[0]);
        chk("rnd_in_ready", in_ready, rxq.size() < DEPTH);
        if (orr && txq.size() != 0) void'(txq.pop_front());
        if (iv && rxq.size() < DEPTH) rxq.push_back(d);
        @(negedge PCLK);
        in_valid = 1'b0; out_ready = 1'b0;
      end
    end
    apb(1'b0, 2'd1, 16'h0, rd, err, w);
    chk("rnd_final_status", rd, exp_status(txq.size(), rxq.size(), sticky));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
